// File: rtl/frodo_pkg.sv
// Shared definitions for the Frodo instruction sequencer: encodings, latencies
// and the three stored micro-programs.
package frodo_pkg;

    localparam int INST_W = 28;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        OP_LOAD   = 3'b000,
        OP_STORE  = 3'b001,
        OP_GEN    = 3'b010,
        OP_SAMPLE = 3'b011,
        OP_MATMUL = 3'b100,
        OP_MATADD = 3'b101,
        OP_ENCODE = 3'b110,
        OP_END    = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        LVL_RSVD = 2'b00,
        LVL_640  = 2'b01,
        LVL_976  = 2'b10,
        LVL_1344 = 2'b11
    } level_e;

    typedef enum logic [1:0] {
        MODE_KEYGEN = 2'b00,
        MODE_ENCAPS = 2'b01,
        MODE_DECAPS = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_EXEC  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] LAT_GEN_SAMPLE = 8'd16;
    localparam logic [CNT_W-1:0] LAT_ENCODE     = 8'd8;

    localparam int N_640  = 640;
    localparam int N_976  = 976;
    localparam int N_1344 = 1344;

    function automatic logic [CNT_W-1:0] mat_latency(input logic [1:0] lvl);
        case (lvl)
            LVL_976:  return CNT_W'(N_976 / 8);
            LVL_1344: return CNT_W'(N_1344 / 8);
            default:  return CNT_W'(N_640 / 8);
        endcase
    endfunction

    // The low pad is 5 bits so the opcode sits in the top 3 bits of the 28-bit word.
    function automatic logic [INST_W-1:0] mem_inst(input logic [2:0] op, input logic [11:0] addr,
                                                   input logic [5:0] len, input logic [1:0] port);
        return {op, addr, len, port, 5'b0};
    endfunction

    function automatic logic [INST_W-1:0] cmp_inst(input logic [2:0] op, input logic [3:0] a,
                                                   input logic [3:0] b, input logic [3:0] c,
                                                   input logic [1:0] md);
        return {op, a, b, c, md, 11'b0};
    endfunction

    localparam logic [INST_W-1:0] I_LOAD   = mem_inst(OP_LOAD, 12'd100, 6'd4, 2'd0);
    localparam logic [INST_W-1:0] I_STORE  = mem_inst(OP_STORE, 12'd200, 6'd2, 2'd0);
    localparam logic [INST_W-1:0] I_GEN    = cmp_inst(OP_GEN, 4'd0, 4'd0, 4'd0, 2'd0);
    localparam logic [INST_W-1:0] I_SAMPLE = cmp_inst(OP_SAMPLE, 4'd0, 4'd0, 4'd0, 2'd0);
    localparam logic [INST_W-1:0] I_MATMUL = cmp_inst(OP_MATMUL, 4'd1, 4'd2, 4'd3, 2'd0);
    localparam logic [INST_W-1:0] I_MATADD = cmp_inst(OP_MATADD, 4'd0, 4'd3, 4'd1, 2'd0);
    localparam logic [INST_W-1:0] I_ENC    = cmp_inst(OP_ENCODE, 4'd0, 4'd0, 4'd2, 2'd0);
    localparam logic [INST_W-1:0] I_DEC    = cmp_inst(OP_ENCODE, 4'd0, 4'd0, 4'd3, 2'd1);
    localparam logic [INST_W-1:0] I_END    = cmp_inst(OP_END, 4'd0, 4'd0, 4'd0, 2'd0);

    localparam logic [INST_W-1:0] PROG_KEYGEN [16] = '{
        I_LOAD, I_GEN, I_SAMPLE, I_MATMUL, I_MATADD, I_STORE, I_END, I_END,
        I_END, I_END, I_END, I_END, I_END, I_END, I_END, I_END
    };

    localparam logic [INST_W-1:0] PROG_ENCAPS [16] = '{
        I_LOAD, I_GEN, I_SAMPLE, I_MATMUL, I_MATADD, I_ENC, I_STORE, I_END,
        I_END, I_END, I_END, I_END, I_END, I_END, I_END, I_END
    };

    localparam logic [INST_W-1:0] PROG_DECAPS [16] = '{
        I_LOAD, I_MATMUL, I_DEC, I_GEN, I_SAMPLE, I_MATMUL, I_MATADD, I_STORE,
        I_END, I_END, I_END, I_END, I_END, I_END, I_END, I_END
    };

endpackage

// File: rtl/frodo_prog_rom.sv
// Combinational micro-program store: (mode, pc) -> instruction word.
module frodo_prog_rom
    import frodo_pkg::*;
(
    input  logic [1:0]        i_mode,
    input  logic [3:0]        i_pc,
    output logic [INST_W-1:0] o_inst
);

    always_comb begin
        case (i_mode)
            MODE_ENCAPS: o_inst = PROG_ENCAPS[i_pc];
            MODE_DECAPS: o_inst = PROG_DECAPS[i_pc];
            default:     o_inst = PROG_KEYGEN[i_pc];
        endcase
    end

endmodule

// File: rtl/frodo_top.sv
// Frodo instruction sequencer: issues a stored program, models per-instruction
// latency and guards the whole run with a watchdog.
module frodo_top
    import frodo_pkg::*;
#(
    parameter int INST_WIDTH = 28,
    parameter int ADDR_WIDTH = 12,
    parameter int TIME       = 10000000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            level,
    input  logic [1:0]            mode_ctrl,
    input  logic                  start,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int WD_W    = $clog2(TIME + 1);
    localparam int LEN_LSB = INST_WIDTH - 3 - ADDR_WIDTH - 6;

    state_e                r_state, w_state_next;
    logic [1:0]            r_level, r_mode;
    logic [3:0]            r_pc;
    logic [CNT_W-1:0]      r_cnt;
    logic [WD_W-1:0]       r_wdog;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_error;

    logic [INST_W-1:0]     w_rom_inst;
    logic [1:0]            w_rom_mode;
    logic [3:0]            w_rom_pc;
    logic [2:0]            w_opcode;
    logic [5:0]            w_len;
    logic [CNT_W-1:0]      w_lat;
    logic                  w_busy, w_start_ok, w_start_bad, w_timeout, w_load_inst;

    assign w_busy      = (r_state == S_ISSUE) || (r_state == S_EXEC);
    assign w_start_ok  = (r_state == S_IDLE) && start && (level != LVL_RSVD) && (mode_ctrl != MODE_RSVD);
    assign w_start_bad = (r_state == S_IDLE) && start && ((level == LVL_RSVD) || (mode_ctrl == MODE_RSVD));
    assign w_timeout   = w_busy && (r_wdog == WD_W'(TIME - 1));

    // The first instruction is fetched straight from the inputs on the accepting edge.
    assign w_rom_mode = (r_state == S_IDLE) ? mode_ctrl : r_mode;
    assign w_rom_pc   = (r_state == S_IDLE) ? 4'd0 : r_pc;

    frodo_prog_rom u_rom (
        .i_mode (w_rom_mode),
        .i_pc   (w_rom_pc),
        .o_inst (w_rom_inst)
    );

    assign w_opcode = r_inst[INST_WIDTH-1 -: 3];
    assign w_len    = r_inst[LEN_LSB +: 6];

    always_comb begin
        w_lat = '0;
        case (w_opcode)
            OP_LOAD, OP_STORE:   w_lat = CNT_W'(w_len) + CNT_W'(1);
            OP_GEN, OP_SAMPLE:   w_lat = LAT_GEN_SAMPLE;
            OP_MATMUL, OP_MATADD: w_lat = mat_latency(r_level);
            OP_ENCODE:           w_lat = LAT_ENCODE;
            default:             w_lat = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_load_inst  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = S_ISSUE;
                    w_load_inst  = 1'b1;
                end
            end
            S_ISSUE: w_state_next = (w_opcode == OP_END) ? S_DONE : S_EXEC;
            S_EXEC: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_next = S_ISSUE;
                    w_load_inst  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_IDLE;
            w_load_inst  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_level <= '0;
            r_mode  <= '0;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_wdog  <= '0;
            r_inst  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load_inst)
                r_inst <= w_rom_inst;
            if (r_state == S_ISSUE) begin
                r_cnt <= w_lat;
                r_pc  <= r_pc + 4'd1;
            end else if (r_state == S_EXEC) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_busy)
                r_wdog <= r_wdog + WD_W'(1);
            if (w_start_ok) begin
                r_level <= level;
                r_mode  <= mode_ctrl;
                r_pc    <= '0;
                r_wdog  <= '0;
                r_error <= 1'b0;
            end else if (w_start_bad || w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign inst       = r_inst;
    assign inst_valid = (r_state == S_ISSUE);
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign error      = r_error;

endmodule

// File: tb/tb_frodo_top.sv
// Scoreboard bench for frodo_top: directed program runs with hand-derived
// instruction words and issue spacing; a second instance exercises the watchdog.
module tb_frodo_top;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  level = 2'b00;
    logic [1:0]  mode_ctrl = 2'b00;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [27:0] inst, inst2;
    logic        inst_valid, busy, done, error;
    logic        inst_valid2, busy2, done2, error2;

    always #5 clk = ~clk;

    frodo_top dut (
        .clk(clk), .rstn(rstn), .level(level), .mode_ctrl(mode_ctrl), .start(start),
        .inst(inst), .inst_valid(inst_valid), .busy(busy), .done(done), .error(error)
    );

    frodo_top #(.TIME(50)) dut2 (
        .clk(clk), .rstn(rstn), .level(level), .mode_ctrl(mode_ctrl), .start(start2),
        .inst(inst2), .inst_valid(inst_valid2), .busy(busy2), .done(done2), .error(error2)
    );

    localparam logic [27:0] T_LOAD   = 28'h00C8200;
    localparam logic [27:0] T_STORE  = 28'h2190100;
    localparam logic [27:0] T_GEN    = 28'h4000000;
    localparam logic [27:0] T_SAMPLE = 28'h6000000;
    localparam logic [27:0] T_MATMUL = 28'h8246000;
    localparam logic [27:0] T_MATADD = 28'hA062000;
    localparam logic [27:0] T_ENC0   = 28'hC004000;
    localparam logic [27:0] T_ENC1   = 28'hC006800;
    localparam logic [27:0] T_END    = 28'hE000000;

    typedef struct {
        logic [27:0] inst;
        int          gap;
    } exp_t;

    exp_t sb_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [27:0] i, input int g);
        exp_t e;
        e.inst = i;
        e.gap  = g;
        sb_q.push_back(e);
    endtask

    // Gap = cycles since the previous issue (first issue: since start was driven).
    task automatic start_prog(input logic [1:0] lv, input logic [1:0] md);
        level     = lv;
        mode_ctrl = md;
        start     = 1'b1;
        last_cyc  = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain"}, sb_q.size() + done_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every issue and every done pulse.
    always @(negedge clk) begin
        if (rstn) begin
            if (inst_valid) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_issue: got inst=%h, expected no issue", inst);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("issue cyc=%0d inst=%h gap=%0d", cyc, inst, cyc - last_cyc);
                    check("issue_inst", {4'b0, inst}, {4'b0, e.inst});
                    check("issue_gap", cyc - last_cyc, e.gap);
                end
                last_cyc = cyc;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_done: got done=1, expected 0");
                end else begin
                    int g;
                    g = done_q.pop_front();
                    $display("done  cyc=%0d gap=%0d busy=%0b error=%0b", cyc, cyc - last_cyc, busy, error);
                    check("done_gap", cyc - last_cyc, g);
                    check("done_busy", busy, 0);
                    check("done_error", error, 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_busy, n_iv, n_done, err_at;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", {4'b0, inst}, 0);
        check("rst_flags", {inst_valid, busy, done, error}, 0);
        check("rst_flags2", {inst_valid2, busy2, done2, error2}, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Encaps at Frodo-1344
        push(T_LOAD, 1);   push(T_GEN, 6);     push(T_SAMPLE, 17); push(T_MATMUL, 17);
        push(T_MATADD, 169); push(T_ENC0, 169); push(T_STORE, 9);  push(T_END, 4);
        done_q.push_back(1);
        start_prog(2'b11, 2'b01);
        check("enc_busy", busy, 1);
        wait_idle("encaps", 1000);
        check("enc_error", error, 0);

        // Keygen at Frodo-640
        push(T_LOAD, 1);   push(T_GEN, 6);     push(T_SAMPLE, 17); push(T_MATMUL, 17);
        push(T_MATADD, 81); push(T_STORE, 81); push(T_END, 4);
        done_q.push_back(1);
        start_prog(2'b01, 2'b00);
        wait_idle("keygen", 1000);

        // Decaps at Frodo-976 with a second start and changed inputs mid-run
        push(T_LOAD, 1);   push(T_MATMUL, 6);  push(T_ENC1, 123);  push(T_GEN, 9);
        push(T_SAMPLE, 17); push(T_MATMUL, 17); push(T_MATADD, 123); push(T_STORE, 123);
        push(T_END, 4);
        done_q.push_back(1);
        start_prog(2'b10, 2'b10);
        repeat (50) @(posedge clk);
        #1;
        level = 2'b01; mode_ctrl = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_keeps_busy", busy, 1);
        wait_idle("decaps", 1500);

        // Reserved level, then reserved mode
        start_prog(2'b00, 2'b01);
        check("rsvd_lvl_error", error, 1);
        check("rsvd_lvl_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        check("rsvd_lvl_idle", {inst_valid, busy}, 0);
        start_prog(2'b11, 2'b11);
        check("rsvd_mode_error", error, 1);
        check("rsvd_mode_busy", busy, 0);

        // Valid start clears error and runs normally
        push(T_LOAD, 1);   push(T_GEN, 6);     push(T_SAMPLE, 17); push(T_MATMUL, 17);
        push(T_MATADD, 81); push(T_STORE, 81); push(T_END, 4);
        done_q.push_back(1);
        start_prog(2'b01, 2'b00);
        check("restart_error_clear", error, 0);
        check("restart_busy", busy, 1);
        wait_idle("keygen2", 1000);

        // Reset mid-run
        push(T_LOAD, 1);   push(T_GEN, 6);     push(T_SAMPLE, 17); push(T_MATMUL, 17);
        push(T_MATADD, 169); push(T_ENC0, 169); push(T_STORE, 9);  push(T_END, 4);
        done_q.push_back(1);
        start_prog(2'b11, 2'b01);
        repeat (30) @(posedge clk);
        #1;
        check("midrst_remaining", sb_q.size(), 5);
        rstn = 1'b0;
        #1;
        check("midrst_inst", {4'b0, inst}, 0);
        check("midrst_flags", {inst_valid, busy, done, error}, 0);
        sb_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Watchdog instance (TIME=50) running encaps
        level = 2'b11; mode_ctrl = 2'b01; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n_busy = 0; n_iv = 0; n_done = 0; err_at = -1;
        for (int k = 0; k < 70; k++) begin
            if (busy2) n_busy++;
            if (inst_valid2) n_iv++;
            if (done2) n_done++;
            if (error2 && err_at < 0) err_at = k;
            @(posedge clk); #1;
        end
        $display("wdog busy_cycles=%0d issues=%0d dones=%0d error_at=%0d", n_busy, n_iv, n_done, err_at);
        check("wdog_busy_cycles", n_busy, 50);
        check("wdog_issues", n_iv, 4);
        check("wdog_no_done", n_done, 0);
        check("wdog_error_at", err_at, 50);
        check("wdog_final", {busy2, error2}, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
